// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory, the core's memory stage and the copy engine.
// Address and byte types are fixed at 8 bits for the 256x8 data memory.
package dmem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        COPY_RD,
        COPY_WR,
        DONE
    } copy_state_t;

endpackage

// File: rtl/dmem_copy_engine.sv
// Owns the data memory port: passes core load/stores through while idle and
// runs a forward byte-by-byte block copy on command, stalling the core meanwhile.
module dmem_copy_engine
    import dmem_pkg::copy_state_t;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    input  logic              core_memWrite,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data_in,
    output logic [DATA_W-1:0] core_data_out,
    output logic              core_stall,
    output logic              mem_memWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    copy_state_t       state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] byte_q;
    logic              busy_q;
    logic              done_q;

    // busy/done are registered alongside the state so they never glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= dmem_pkg::IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                dmem_pkg::IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            src_q   <= src_addr;
                            dst_q   <= dst_addr;
                            len_q   <= len;
                            idx_q   <= '0;
                            state_q <= dmem_pkg::COPY_RD;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= dmem_pkg::DONE;
                        end
                    end
                end
                dmem_pkg::COPY_RD: begin
                    byte_q  <= mem_data_out;
                    state_q <= dmem_pkg::COPY_WR;
                end
                dmem_pkg::COPY_WR: begin
                    if (idx_q == len_q - ADDR_W'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= dmem_pkg::DONE;
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                        state_q <= dmem_pkg::COPY_RD;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= dmem_pkg::IDLE;
                end
            endcase
        end
    end

    // Address arithmetic wraps naturally at ADDR_W bits.
    always_comb begin
        mem_memWrite = core_memWrite;
        mem_addr     = core_addr;
        mem_data_in  = core_data_in;
        case (state_q)
            dmem_pkg::COPY_RD: begin
                mem_memWrite = 1'b0;
                mem_addr     = src_q + idx_q;
                mem_data_in  = byte_q;
            end
            dmem_pkg::COPY_WR: begin
                mem_memWrite = 1'b1;
                mem_addr     = dst_q + idx_q;
                mem_data_in  = byte_q;
            end
            dmem_pkg::DONE: begin
                mem_memWrite = 1'b0;
                mem_addr     = dst_q + idx_q;
                mem_data_in  = byte_q;
            end
            default: ;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign core_stall    = busy_q;
    assign core_data_out = mem_data_out;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine attached to a 256x8 data memory with
// combinational read and posedge write.
module tb_dmem_copy_engine;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       core_memWrite;
    logic [7:0] core_addr;
    logic [7:0] core_data_in;
    logic [7:0] core_data_out;
    logic       core_stall;
    logic       mem_memWrite;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    logic [7:0] memArray [0:255];
    int         writeCount;
    int         compared;
    int         mismatched;
    int         writeSnap;

    dmem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .core_memWrite (core_memWrite),
        .core_addr     (core_addr),
        .core_data_in  (core_data_in),
        .core_data_out (core_data_out),
        .core_stall    (core_stall),
        .mem_memWrite  (mem_memWrite),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: asynchronous read, write on the rising edge.
    assign mem_data_out = memArray[mem_addr];
    always @(posedge clock) begin
        if (mem_memWrite) begin
            memArray[mem_addr] <= mem_data_in;
            writeCount <= writeCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] src,
                                 input logic [7:0] dst, input logic [7:0] n);
        start    = s;
        src_addr = src;
        dst_addr = dst;
        len      = n;
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        writeCount    = 0;
        reset_n       = 1'b0;
        core_memWrite = 1'b0;
        core_addr     = 8'h00;
        core_data_in  = 8'h00;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) memArray[i] = 8'h00;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_stall", core_stall, 1'b0);
        checkOutput("reset_we", mem_memWrite, 1'b0);
        reset_n = 1'b1;

        // Pass-through store then load
        @(negedge clock);
        writeSnap     = writeCount;
        core_memWrite = 1'b1;
        core_addr     = 8'h10;
        core_data_in  = 8'h5A;
        #1;
        checkOutput("pt_we", mem_memWrite, 1'b1);
        checkOutput("pt_addr", mem_addr, 8'h10);
        checkOutput("pt_wdata", mem_data_in, 8'h5A);
        @(negedge clock);
        core_memWrite = 1'b0;
        #1;
        checkOutput("pt_load", core_data_out, 8'h5A);
        checkOutput("pt_busy", busy, 1'b0);
        checkOutput("pt_writes", writeCount - writeSnap, 1);

        // Basic copy with ignored start and ignored core store mid-copy
        memArray[8'h20] = 8'h11;
        memArray[8'h21] = 8'h22;
        memArray[8'h22] = 8'h33;
        memArray[8'h23] = 8'h44;
        memArray[8'h40] = 8'h77;
        writeSnap = writeCount;
        applyStimulus(1'b1, 8'h20, 8'h80, 8'd4);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("copy_busy_c%0d", c), busy, (c <= 9) ? 1'b1 : 1'b0);
            checkOutput($sformatf("copy_stall_c%0d", c), core_stall, (c <= 9) ? 1'b1 : 1'b0);
            checkOutput($sformatf("copy_done_c%0d", c), done, (c == 9) ? 1'b1 : 1'b0);
            applyStimulus((c == 3) ? 1'b1 : 1'b0, 8'h00, 8'h00, 8'd1);
            core_memWrite = (c >= 2 && c <= 5) ? 1'b1 : 1'b0;
            core_addr     = 8'h40;
            core_data_in  = 8'hEE;
        end
        checkOutput("copy_b0", memArray[8'h80], 8'h11);
        checkOutput("copy_b1", memArray[8'h81], 8'h22);
        checkOutput("copy_b2", memArray[8'h82], 8'h33);
        checkOutput("copy_b3", memArray[8'h83], 8'h44);
        checkOutput("copy_writes", writeCount - writeSnap, 4);
        checkOutput("busy_store_ignored", memArray[8'h40], 8'h77);
        checkOutput("restart_ignored", memArray[8'h00], 8'h00);

        // Wrap-around fill: dst = src + 1 replicates the source byte
        memArray[8'hFE] = 8'hAB;
        memArray[8'h02] = 8'h5C;
        applyStimulus(1'b1, 8'hFE, 8'hFF, 8'd3);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            checkOutput($sformatf("wrap_done_c%0d", c), done, (c == 7) ? 1'b1 : 1'b0);
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        end
        checkOutput("wrap_ff", memArray[8'hFF], 8'hAB);
        checkOutput("wrap_00", memArray[8'h00], 8'hAB);
        checkOutput("wrap_01", memArray[8'h01], 8'hAB);
        checkOutput("wrap_02_untouched", memArray[8'h02], 8'h5C);

        // Zero-length request
        writeSnap = writeCount;
        applyStimulus(1'b1, 8'h20, 8'h90, 8'd0);
        @(negedge clock);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("len0_done_c1", done, 1'b1);
        checkOutput("len0_busy_c1", busy, 1'b1);
        @(negedge clock);
        checkOutput("len0_done_c2", done, 1'b0);
        checkOutput("len0_busy_c2", busy, 1'b0);
        checkOutput("len0_writes", writeCount - writeSnap, 0);

        // Reset asserted after the third write of an 8-byte copy
        for (int i = 0; i < 8; i++) begin
            memArray[8'h30 + i] = 8'hA0 + 8'(i);
            memArray[8'h90 + i] = 8'h00;
        end
        writeSnap = writeCount;
        applyStimulus(1'b1, 8'h30, 8'h90, 8'd8);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst_done_held", done, 1'b0);
        reset_n = 1'b1;
        checkOutput("rst_writes", writeCount - writeSnap, 3);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("rst_dst%0d", i), memArray[8'h90 + i],
                        (i < 3) ? (8'hA0 + 8'(i)) : 8'h00);
        end

        // Engine usable again after the abort
        @(negedge clock);
        applyStimulus(1'b1, 8'h30, 8'hC0, 8'd2);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            checkOutput($sformatf("post_done_c%0d", c), done, (c == 5) ? 1'b1 : 1'b0);
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        end
        checkOutput("post_c0", memArray[8'hC0], 8'hA0);
        checkOutput("post_c1", memArray[8'hC1], 8'hA1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Sits directly upstream of the 256x8 data memory and owns its single port: memWrite, addr, data_in, and the combinational data_out.
- In idle it passes the core's load/store port straight through to the memory.
- On command it runs a byte-by-byte block copy (src -> dst, len bytes) inside data memory and stalls the core until the copy finishes.
- Used for array moves and pattern fills without per-byte program loops.

Parameters:
- ADDR_W, 8, address width; data memory depth is 2**ADDR_W.
- DATA_W, 8, byte width of the memory word.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  copy request; sampled only in IDLE.
- src_addr  input  ADDR_W  first source byte address.
- dst_addr  input  ADDR_W  first destination byte address.
- len  input  ADDR_W  byte count; 0 means no-op.
- busy  output  1  high in COPY_RD, COPY_WR, DONE.
- done  output  1  one-cycle completion pulse.
- core_memWrite  input  1  core store strobe.
- core_addr  input  ADDR_W  core load/store address.
- core_data_in  input  DATA_W  core store data.
- core_data_out  output  DATA_W  load data to core; always equals mem_data_out.
- core_stall  output  1  equals busy; the core must hold its request while it is high.
- mem_memWrite  output  1  to data memory write enable.
- mem_addr  output  ADDR_W  to data memory address.
- mem_data_in  output  DATA_W  to data memory write data.
- mem_data_out  input  DATA_W  from data memory; combinational read of mem_addr.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; busy=0, done=0.
  - src_q, dst_q, len_q, idx, byte_q cleared to 0.
  - The engine never asserts mem_memWrite in reset; memory outputs follow the core pass-through.
- IDLE:
  - mem_memWrite=core_memWrite, mem_addr=core_addr, mem_data_in=core_data_in (combinational); core_stall=0.
  - start=1 and len!=0: capture src_addr, dst_addr, len; idx<=0; next state COPY_RD.
  - start=1 and len==0: next state DONE (no memory access).
  - A core store in the same cycle as start completes normally, because pass-through is still active that cycle.
- COPY_RD:
  - mem_addr=src_q+idx (mod 2**ADDR_W), mem_memWrite=0.
  - byte_q<=mem_data_out at the clock edge; next state COPY_WR.
- COPY_WR:
  - mem_addr=dst_q+idx (mod 2**ADDR_W), mem_data_in=byte_q, mem_memWrite=1.
  - If idx==len_q-1, next state DONE; otherwise idx<=idx+1 and next state COPY_RD.
- DONE:
  - done=1 for exactly this cycle; mem_memWrite=0; next state IDLE.
- Core isolation while busy:
  - core_memWrite is not forwarded; core_addr is not forwarded.
  - core_data_out shows engine read data and is not valid for the core.
- Latency:
  - start sampled at edge E0; first write at cycle 2; last write at cycle 2*len.
  - done is high in cycle 2*len+1 (cycle 1 for len=0); core resumes the cycle after.
- Boundary rules:
  - start while busy is ignored; no queuing.
  - Addresses wrap modulo 256: src=0xFE, len=4 reads 0xFE, 0xFF, 0x00, 0x01.
  - Overlap is a strictly forward copy with read-before-write per byte. dst=src+1 therefore replicates byte[src] across len bytes, and this is the supported fill idiom. memmove semantics are not provided.
  - Reset asserted mid-copy aborts immediately: no further writes, done not pulsed, bytes already written stay written.
- Width: idx, len_q, src_q, dst_q are ADDR_W bits. len=255 is the maximum count.

Decomposition:
- Package dmem_pkg:
  - ADDR_W and DATA_W localparams.
  - typedef enum logic [1:0] {IDLE, COPY_RD, COPY_WR, DONE} copy_state_t.
  - typedefs addr_t and byte_t, shared with the data memory and the core's memory stage.
- No sub-module. One FSM with its datapath registers plus the combinational port mux.
- The bench instantiates this block together with the existing data memory.

Test Plan:
- Pass-through: IDLE, core store 0x5A to 0x10, then load 0x10 -> mem_memWrite pulses once; core_data_out=0x5A; busy stays 0.
- Basic copy: preload 0x20..0x23={11,22,33,44}; start src=0x20, dst=0x80, len=4 -> 0x80..0x83={11,22,33,44}; done high in cycle 9 only; core_stall=1 in cycles 1..9.
- Wrap and fill: preload 0xFE=0xAB; start src=0xFE, dst=0xFF, len=3 -> 0xFF, 0x00, 0x01 all 0xAB.
- len=0: start len=0 -> zero writes; done pulses in cycle 1; back in IDLE in cycle 2.
- Ignored events:
  - start reasserted mid-copy has no effect on the first copy.
  - core_memWrite=1 to 0x40 during busy leaves 0x40 unchanged.
- Reset mid-op: start len=8; drop reset_n after the 3rd write -> busy=0 and done=0 immediately; only the first 3 destination bytes changed; next start works normally.
